// File: rtl/trace_capture_if.sv
// Probe, control and readout bundle for the pipeline trace buffer.
// The master side drives the probes, the controls and the read address; the slave side is the tracer.
interface trace_capture_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 32
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CHANNELS*WIDTH-1:0] sample_i;
    logic [CHANNELS-1:0]       valid_i;
    logic [CHANNELS-1:0]       chan_en_i;
    logic                      mode_i;
    logic                      arm_i;
    logic                      trig_i;
    logic [PTR_W-1:0]          post_cnt_i;
    logic                      clear_i;
    logic [PTR_W-1:0]          rd_addr_i;
    logic [CHANNELS*WIDTH-1:0] rd_data_o;
    logic [CHANNELS-1:0]       rd_mask_o;
    logic [TS_W-1:0]           rd_ts_o;
    logic                      rd_valid_o;
    logic [1:0]                state_o;
    logic [PTR_W:0]            count_o;
    logic [PTR_W-1:0]          trig_idx_o;
    logic                      done_o;

    modport master (
        output sample_i, valid_i, chan_en_i, mode_i, arm_i, trig_i, post_cnt_i, clear_i, rd_addr_i,
        input  rd_data_o, rd_mask_o, rd_ts_o, rd_valid_o, state_o, count_o, trig_idx_o, done_o
    );

    modport slave (
        input  sample_i, valid_i, chan_en_i, mode_i, arm_i, trig_i, post_cnt_i, clear_i, rd_addr_i,
        output rd_data_o, rd_mask_o, rd_ts_o, rd_valid_o, state_o, count_o, trig_idx_o, done_o
    );
endinterface

// File: rtl/trace_capture.sv
// Circular pipeline trace buffer with an arm/trigger/post-trigger sequencer, per-entry
// timestamps and a registered random-access readout indexed from the oldest entry.
module trace_capture #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    trace_capture_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [TS_W-1:0]  TS_ONE   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_nextState;
    logic [TS_W-1:0]           r_ts;
    logic [PTR_W-1:0]          r_wptr;
    logic [PTR_W:0]            r_count;
    logic [PTR_W-1:0]          r_remaining;
    logic [PTR_W-1:0]          r_trigPtr;

    logic [CHANNELS*WIDTH-1:0] r_memData [DEPTH];
    logic [CHANNELS-1:0]       r_memMask [DEPTH];
    logic [TS_W-1:0]           r_memTs   [DEPTH];

    logic [CHANNELS*WIDTH-1:0] r_rdData;
    logic [CHANNELS-1:0]       r_rdMask;
    logic [TS_W-1:0]           r_rdTs;
    logic                      r_rdValid;

    logic [CHANNELS-1:0]       w_effMask;
    logic [CHANNELS*WIDTH-1:0] w_storeData;
    logic                      w_trigHit;
    logic                      w_cap;
    logic [PTR_W-1:0]          w_oldest;
    logic [PTR_W-1:0]          w_physAddr;
    logic                      w_rdValid;

    assign w_effMask = bus.valid_i & bus.chan_en_i;
    assign w_trigHit = (r_state == ARMED) && bus.trig_i;
    // The trigger entry is captured even when mode 1 would otherwise filter the cycle out.
    assign w_cap     = w_trigHit ||
                       (((r_state == ARMED) || (r_state == POST)) && (!bus.mode_i || (|w_effMask)));

    always_comb begin
        w_storeData = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.chan_en_i[k]) begin
                w_storeData[k*WIDTH +: WIDTH] = bus.sample_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:  if (bus.arm_i) w_nextState = ARMED;
            ARMED: begin
                if (bus.trig_i) begin
                    w_nextState = (bus.post_cnt_i == '0) ? DONE : POST;
                end else if (!bus.arm_i) begin
                    w_nextState = IDLE;
                end
            end
            POST:  if (w_cap && (r_remaining == PTR_ONE)) w_nextState = DONE;
            DONE:  if (bus.clear_i) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ts        <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_trigPtr   <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
            if ((r_state == IDLE) && bus.arm_i) begin
                r_wptr  <= '0;
                r_count <= '0;
            end else if (w_cap) begin
                r_wptr  <= r_wptr + PTR_ONE;
                r_count <= (r_count == CNT_FULL) ? CNT_FULL : r_count + CNT_ONE;
            end
            if (w_trigHit) begin
                r_trigPtr   <= r_wptr;
                r_remaining <= bus.post_cnt_i;
            end else if ((r_state == POST) && w_cap) begin
                r_remaining <= r_remaining - PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_cap) begin
            r_memData[r_wptr] <= w_storeData;
            r_memMask[r_wptr] <= w_effMask;
            r_memTs[r_wptr]   <= r_ts;
        end
    end

    // Once the buffer has wrapped, the write pointer marks the oldest surviving entry.
    assign w_oldest   = (r_count < CNT_FULL) ? '0 : r_wptr;
    assign w_physAddr = w_oldest + bus.rd_addr_i;
    assign w_rdValid  = {1'b0, bus.rd_addr_i} < r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdData  <= '0;
            r_rdMask  <= '0;
            r_rdTs    <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdValid;
            r_rdData  <= w_rdValid ? r_memData[w_physAddr] : '0;
            r_rdMask  <= w_rdValid ? r_memMask[w_physAddr] : '0;
            r_rdTs    <= w_rdValid ? r_memTs[w_physAddr]   : '0;
        end
    end

    assign bus.rd_data_o  = r_rdData;
    assign bus.rd_mask_o  = r_rdMask;
    assign bus.rd_ts_o    = r_rdTs;
    assign bus.rd_valid_o = r_rdValid;
    assign bus.state_o    = r_state;
    assign bus.count_o    = r_count;
    assign bus.done_o     = (r_state == DONE);
    assign bus.trig_idx_o = (r_state == DONE) ? (r_trigPtr - w_oldest) : '0;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: reset, plain and wrapped captures, mode 1 filtering,
// abort/clear behaviour and an immediate zero-length post-trigger run.
module tb_trace_capture;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int TS_W     = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] tbTs;
    logic [15:0] t0;
    logic [15:0] trigTs;
    logic [15:0] lastTs;
    logic [15:0] firstTs;
    logic [15:0] tsA;
    logic [15:0] tsB;
    logic [15:0] tsT;
    logic [15:0] tsZ;

    trace_capture_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

    trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] expData(input logic [15:0] ts);
        logic [7:0] lo;
        lo = ts[7:0];
        return {lo + 8'h80, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) tbTs = tbTs + 16'd1;
        #1;
    endtask

    // Drives one cycle of inputs (probe data derived from the current timestamp) and clocks it in.
    task automatic applyStimulus(input logic arm, input logic trig, input logic clear, input logic mode,
                                 input logic [1:0] valid, input logic [1:0] chanEn,
                                 input logic [2:0] postCnt, input logic [2:0] rdAddr);
        bus.arm_i      = arm;
        bus.trig_i     = trig;
        bus.clear_i    = clear;
        bus.mode_i     = mode;
        bus.valid_i    = valid;
        bus.chan_en_i  = chanEn;
        bus.post_cnt_i = postCnt;
        bus.rd_addr_i  = rdAddr;
        bus.sample_i   = expData(tbTs);
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tbTs   = 16'd0;
        rst    = 1'b0;

        // Reset held with arm asserted
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("rst_state", 32'(bus.state_o), 32'd0);
        checkOutput("rst_count", 32'(bus.count_o), 32'd0);
        checkOutput("rst_rdvalid", 32'(bus.rd_valid_o), 32'd0);
        checkOutput("rst_rddata", 32'(bus.rd_data_o), 32'd0);
        checkOutput("rst_rdts", 32'(bus.rd_ts_o), 32'd0);
        checkOutput("rst_rdmask", 32'(bus.rd_mask_o), 32'd0);
        checkOutput("rst_done", 32'(bus.done_o), 32'd0);
        checkOutput("rst_trigidx", 32'(bus.trig_idx_o), 32'd0);

        rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("arm_state", 32'(bus.state_o), 32'd1);
        checkOutput("arm_count", 32'(bus.count_o), 32'd0);

        // No-wrap trigger in mode 0
        t0 = tbTs;
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("pre_count", 32'(bus.count_o), 32'd3);
        trigTs = tbTs;
        applyStimulus(1, 1, 0, 0, 2'b11, 2'b11, 3'd2, 3'd0);
        checkOutput("post_state", 32'(bus.state_o), 32'd2);
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        lastTs = tbTs;
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("t1_state", 32'(bus.state_o), 32'd3);
        checkOutput("t1_done", 32'(bus.done_o), 32'd1);
        checkOutput("t1_count", 32'(bus.count_o), 32'd6);
        checkOutput("t1_trigidx", 32'(bus.trig_idx_o), 32'd3);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd5);
        checkOutput("t1_rd5_valid", 32'(bus.rd_valid_o), 32'd1);
        checkOutput("t1_rd5_ts", 32'(bus.rd_ts_o), 32'(lastTs));
        checkOutput("t1_rd5_data", 32'(bus.rd_data_o), 32'(expData(lastTs)));
        checkOutput("t1_rd5_mask", 32'(bus.rd_mask_o), 32'd3);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd6);
        checkOutput("t1_rd6_valid", 32'(bus.rd_valid_o), 32'd0);
        checkOutput("t1_rd6_data", 32'(bus.rd_data_o), 32'd0);
        checkOutput("t1_rd6_ts", 32'(bus.rd_ts_o), 32'd0);
        checkOutput("t1_rd6_mask", 32'(bus.rd_mask_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd3);
        checkOutput("t1_rd3_ts", 32'(bus.rd_ts_o), 32'(trigTs));
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("t1_rd0_ts", 32'(bus.rd_ts_o), 32'(t0));

        // Wrap: 12 pre-trigger captures then 3 post-trigger captures
        applyStimulus(0, 0, 1, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("clr_state", 32'(bus.state_o), 32'd0);
        checkOutput("clr_count_kept", 32'(bus.count_o), 32'd6);
        checkOutput("clr_trigidx", 32'(bus.trig_idx_o), 32'd0);
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("rearm_count", 32'(bus.count_o), 32'd0);
        firstTs = tbTs;
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("wrap_sat_count", 32'(bus.count_o), 32'd8);
        applyStimulus(1, 1, 0, 0, 2'b11, 2'b11, 3'd3, 3'd0);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 0, 0, 2'b11, 2'b11, 3'd3, 3'd0);
        checkOutput("wrap_post_state", 32'(bus.state_o), 32'd2);
        applyStimulus(1, 1, 0, 0, 2'b11, 2'b11, 3'd3, 3'd0);
        checkOutput("wrap_state", 32'(bus.state_o), 32'd3);
        checkOutput("wrap_count", 32'(bus.count_o), 32'd8);
        checkOutput("wrap_trigidx", 32'(bus.trig_idx_o), 32'd4);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("wrap_rd0_ts", 32'(bus.rd_ts_o), 32'(firstTs + 16'd8));
        checkOutput("wrap_rd0_data", 32'(bus.rd_data_o), 32'(expData(firstTs + 16'd8)));
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd7);
        checkOutput("wrap_rd7_ts", 32'(bus.rd_ts_o), 32'(firstTs + 16'd15));
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd4);
        checkOutput("wrap_rd4_ts", 32'(bus.rd_ts_o), 32'(firstTs + 16'd12));

        // DONE ignores trigger and arm
        applyStimulus(1, 1, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("done_hold_state", 32'(bus.state_o), 32'd3);
        checkOutput("done_hold_count", 32'(bus.count_o), 32'd8);

        // Mode 1 filtering with only channel 0 enabled
        applyStimulus(0, 0, 1, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 1, 2'b11, 2'b01, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 1, 2'b10, 2'b01, 3'd0, 3'd0);
        tsA = tbTs;
        applyStimulus(1, 0, 0, 1, 2'b01, 2'b01, 3'd0, 3'd0);
        tsB = tbTs;
        applyStimulus(1, 0, 0, 1, 2'b11, 2'b01, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 1, 2'b00, 2'b01, 3'd0, 3'd0);
        checkOutput("m1_count", 32'(bus.count_o), 32'd2);
        tsT = tbTs;
        applyStimulus(1, 1, 0, 1, 2'b00, 2'b01, 3'd0, 3'd0);
        checkOutput("m1_state", 32'(bus.state_o), 32'd3);
        checkOutput("m1_count_trig", 32'(bus.count_o), 32'd3);
        checkOutput("m1_trigidx", 32'(bus.trig_idx_o), 32'd2);
        applyStimulus(0, 0, 0, 0, 2'b00, 2'b01, 3'd0, 3'd0);
        checkOutput("m1_rd0_mask", 32'(bus.rd_mask_o), 32'd1);
        checkOutput("m1_rd0_ts", 32'(bus.rd_ts_o), 32'(tsA));
        checkOutput("m1_rd0_data", 32'(bus.rd_data_o), {24'd0, tsA[7:0]});
        applyStimulus(0, 0, 0, 0, 2'b00, 2'b01, 3'd0, 3'd1);
        checkOutput("m1_rd1_mask", 32'(bus.rd_mask_o), 32'd1);
        checkOutput("m1_rd1_ts", 32'(bus.rd_ts_o), 32'(tsB));
        checkOutput("m1_rd1_data", 32'(bus.rd_data_o), {24'd0, tsB[7:0]});
        applyStimulus(0, 0, 0, 0, 2'b00, 2'b01, 3'd0, 3'd2);
        checkOutput("m1_rd2_mask", 32'(bus.rd_mask_o), 32'd0);
        checkOutput("m1_rd2_ts", 32'(bus.rd_ts_o), 32'(tsT));

        // Abort from ARMED keeps the count, including the abort-cycle capture
        applyStimulus(0, 0, 1, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("ab_count_pre", 32'(bus.count_o), 32'd2);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("ab_state", 32'(bus.state_o), 32'd0);
        checkOutput("ab_count", 32'(bus.count_o), 32'd3);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("ab_idle_count", 32'(bus.count_o), 32'd3);

        // Zero post count with trigger and abort on the first ARMED cycle
        applyStimulus(1, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("z_arm_count", 32'(bus.count_o), 32'd0);
        tsZ = tbTs;
        applyStimulus(0, 1, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("z_state", 32'(bus.state_o), 32'd3);
        checkOutput("z_count", 32'(bus.count_o), 32'd1);
        checkOutput("z_trigidx", 32'(bus.trig_idx_o), 32'd0);
        applyStimulus(0, 0, 0, 0, 2'b11, 2'b11, 3'd0, 3'd0);
        checkOutput("z_rd0_ts", 32'(bus.rd_ts_o), 32'(tsZ));
        checkOutput("z_rd0_mask", 32'(bus.rd_mask_o), 32'd3);
        checkOutput("z_rd0_valid", 32'(bus.rd_valid_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Synthesizable, parametrised pipeline trace buffer for the core: a circular RAM that snapshots per-stage debug channels (IF/ID/EX/RF/status words) each cycle.
- Supports an arm/trigger/post-trigger state machine with cycle timestamps and a random-access readout port.
- Sits beside the core and is fed by stage probe buses.
- Replaces per-cycle display dumping with on-chip capture usable in both simulation and hardware.

Parameters:
- WIDTH, 32, bits per channel sample.
- CHANNELS, 4, number of probe channels; CHANNELS >= 1.
- DEPTH, 16, entries in the buffer; power of two, >= 2.
- TS_W, 32, timestamp (cycle counter) width.
- Derived: PTR_W = log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- sample_i  in  CHANNELS*WIDTH  probe data; channel k at bits [k*WIDTH +: WIDTH]
- valid_i  in  CHANNELS  per-channel sample valid
- chan_en_i  in  CHANNELS  channel enable mask
- mode_i  in  1  0 = capture every cycle, 1 = capture only when |(valid_i & chan_en_i)
- arm_i  in  1  arm request; level-sensitive in ARMED
- trig_i  in  1  trigger
- post_cnt_i  in  PTR_W  entries to capture after the trigger entry; sampled on trigger
- clear_i  in  1  return from DONE to IDLE
- rd_addr_i  in  PTR_W  logical read index, 0 = oldest entry
- rd_data_o  out  CHANNELS*WIDTH  read data, masked
- rd_mask_o  out  CHANNELS  stored effective-valid mask
- rd_ts_o  out  TS_W  stored timestamp
- rd_valid_o  out  1  read index was < count
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count_o  out  PTR_W+1  valid entries, saturates at DEPTH
- trig_idx_o  out  PTR_W  logical index of trigger entry
- done_o  out  1  state == DONE

Behaviour:
- Reset (rst=0 at posedge): state IDLE; ts, wptr, count, remaining and trig_ptr cleared to 0. All outputs 0. RAM contents are not cleared.
- ts increments every non-reset cycle, wraps modulo 2^TS_W.
- Capture condition: cap = (state ARMED or POST) && (mode_i==0 || |(valid_i & chan_en_i)).
- On cap, store {ts, m = valid_i & chan_en_i, sample_i with disabled channels zeroed} at mem[wptr].
  - wptr <= wptr+1 mod DEPTH.
  - count <= min(count+1, DEPTH); oldest entry is overwritten on wrap.
- IDLE: arm_i=1 -> ARMED; wptr and count cleared that edge; no capture in the transition cycle.
- ARMED:
  - arm_i=0 -> IDLE (abort); count is retained.
  - trig_i=1 -> the current cycle is captured unconditionally (regardless of mode_i) as the trigger entry; trig_ptr <= wptr.
    - If post_cnt_i==0 -> DONE.
    - Else -> POST, remaining <= post_cnt_i.
  - Trigger and abort in the same cycle: trigger wins.
- POST: each cap decrements remaining; when a cap occurs with remaining==1 -> DONE. trig_i and arm_i are ignored. Since post_cnt_i <= DEPTH-1, the trigger entry is never overwritten.
- DONE: no captures; contents frozen. clear_i=1 -> IDLE (count kept until the next arm). All other inputs are ignored.
- Read:
  - Physical address = (count < DEPTH) ? rd_addr_i : (wptr + rd_addr_i) mod DEPTH.
  - Registered, 1-cycle latency: outputs reflect rd_addr_i from the previous edge.
  - rd_valid_o = (rd_addr_i < count). When invalid, rd_data_o, rd_mask_o and rd_ts_o are 0.
  - Reading is permitted in any state. A same-cycle write to the read location returns the old data.
- trig_idx_o = (trig_ptr - oldest) mod DEPTH, where oldest = (count < DEPTH) ? 0 : wptr. It is 0 outside DONE.
- count_o, state_o and done_o are registered and reflect state after the edge.

Test Plan (DEPTH=8, CHANNELS=2, WIDTH=8, TS_W=16):
- Reset: hold rst=0 for 3 cycles with arm_i=1 -> state_o=0, count_o=0, all read outputs 0. Release at ts=0; arm at cycle 2 -> ARMED by cycle 3.
- No-wrap trigger, mode 0: arm, feed sample=cycle, trig after 3 captures, post_cnt=2 -> DONE with count_o=6, trig_idx_o=3. Reading index 5 one cycle later gives the ts of the last capture; index 6 gives rd_valid_o=0 and zeros.
- Wrap: mode 0, 12 captures before trig, post_cnt=3 -> count_o=8. Index 0 = the 9th entry of 16 written; trig_idx_o=4.
- Mode 1 filtering: chan_en=2'b01, valid_i pattern 10,01,11,00 -> only cycles 2 and 3 captured, rd_mask_o 01,01, channel 1 data 0. A trigger during a valid=00 cycle is still captured.
- Abort and clear: in ARMED drop arm_i -> IDLE with count retained. trig_i and arm_i pulsed in DONE -> no change. clear_i -> IDLE; re-arm -> count_o=0.
- post_cnt=0 with trig on the first ARMED cycle -> DONE next edge, count_o=1, trig_idx_o=0.
